// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller.
// Runs one full-adder cell plus a carry flop over a WIDTH-bit operand pair,
// LSB first, one bit per clock, with a start/busy/done handshake.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only in IDLE
//   a, b   - operands, captured when start is accepted
//   cin    - carry-in for add, captured at start (ignored when sub=1)
//   sub    - 1: a - b, 0: a + b + cin; captured at start
//   busy   - high while an operation is running or completing
//   done   - one-cycle pulse, sum/carry valid
//   sum    - registered result, held until the next completed operation
//   carry  - registered carry-out (subtract: 1 = no borrow)

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             load_c;
    logic             step_c;
    logic             last_c;
    logic             bit_s_c;
    logic             bit_c_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)  state_nxt = S_RUN;
            S_RUN:  if (last_c) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode and the full-adder cell
    always_comb begin
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        bit_s_c = op_a[0] ^ op_b[0] ^ c;
        bit_c_c = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);
        case (state)
            S_IDLE: load_c = start;
            S_RUN: begin
                step_c = 1'b1;
                last_c = (cnt == CW'(WIDTH - 1));
            end
            default: ;
        endcase
    end

    // Datapath: operand shifters, carry flop, bit counter, working result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (load_c) begin
            op_a <= a;
            // Subtraction as a + ~b + 1: invert b and force the carry-in.
            op_b <= sub ? ~b : b;
            c    <= sub ? 1'b1 : cin;
            cnt  <= '0;
            res  <= '0;
        end else if (step_c) begin
            op_a <= op_a >> 1;
            op_b <= op_b >> 1;
            c    <= bit_c_c;
            res  <= {bit_s_c, res[WIDTH-1:1]};
            // Hold on the last bit so the counter never wraps.
            if (!last_c) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result registers, only written on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (last_c) begin
            sum   <= {bit_s_c, res[WIDTH-1:1]};
            carry <= bit_c_c;
        end
    end

    // Status flags registered from the next state, equal to a decode of state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller. It sequences a single 1-bit full-adder cell (half-adder pair plus carry flop) over a WIDTH-bit operand pair, LSB first, one bit per clock. It sits between a requester issuing start/operands and any logic consuming the registered sum/carry result. Resource-light alternative to a parallel WIDTH-bit adder; handshake is start/busy/done.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured at the accepted start
b  input  WIDTH  operand B; captured at the accepted start
cin  input  1  carry-in for add; captured at start
sub  input  1  1 = compute a - b; 0 = compute a + b + cin; captured at start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result
carry  output  1  registered carry-out (in subtract mode: 1 = no borrow)

Behaviour:
- Reset: rst_n is asynchronous and active-low; one clock, clk.
- Reset values: state=IDLE; busy=0; done=0; sum=0; carry=0; internal shift registers, carry flop and bit counter all 0.
- Asserting rst_n low mid-operation aborts immediately: outputs go to reset values without waiting for a clock edge, and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Load opA<=a; opB<=(sub ? ~b : b).
  - c<=(sub ? 1 : cin); cnt<=0; working result register cleared.
  - Go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - s = opA[0]^opB[0]^c; c<=majority(opA[0],opB[0],c).
  - opA and opB shift right by 1.
  - s shifts into the MSB of the working result register (register shifts right).
  - cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge): also load sum<=final working value (including this bit) and carry<=final c. Go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency: start sampled at edge E0 → done high during the cycle following edge E0+WIDTH; sum/carry valid from that same edge.
- Throughput: one operation per WIDTH+2 cycles when start is held high (start re-sampled in IDLE).
- start in RUN or DONE is ignored. Operands, cin and sub may change freely after capture without affecting the result.
- sum/carry hold their value until the next completed operation. They are not disturbed during RUN.
- busy = (state != IDLE); done = (state == DONE), decoded from registered state.
- Arithmetic is modulo 2^WIDTH; carry is bit WIDTH of a + (sub ? ~b+1 : b+cin). cin is ignored when sub=1.
- Counter width is clog2(WIDTH); the counter never wraps past WIDTH-1 during RUN.

Test Plan:
1. WIDTH=8, a=8'h0F, b=8'h01, cin=0, sub=0, start pulsed at edge E0 → busy=1 from E0; done=1 only in the cycle after E0+8; sum=8'h10, carry=0.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, carry=1. Repeat with b=8'h00, cin=1 → sum=8'h00, carry=1.
3. sub=1: a=8'h05, b=8'h07 → sum=8'hFE, carry=0. Then a=8'h07, b=8'h05, cin=1 (must be ignored) → sum=8'h02, carry=1.
4. start held high continuously with operands changed every cycle → done pulses spaced exactly 10 cycles apart. Each result matches the operands present at the corresponding IDLE acceptance edge. Mid-RUN operand changes have no effect.
5. Start an op, deassert rst_n asynchronously after 3 RUN edges → busy/done/sum/carry are 0 immediately, before the next clk edge. After release, a new op (a=8'h12, b=8'h34) gives sum=8'h46, carry=0, with normal latency.
6. WIDTH=4 exhaustive sweep of a, b, cin, sub (1024 ops) against a behavioural model → every sum/carry matches; done count = 1024; done never high for two consecutive cycles.
